// File: rtl/alias_pkg.sv
// Shared types and helpers for the alias_hub block.
// Arbitration mode enum and index-width helper.
package alias_pkg;

  typedef enum logic {
    ALIAS_RR,
    ALIAS_FIXED
  } alias_arb_e;

  // Index width; never below 1 so single-bit fields stay legal.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alias_rr_arbiter.sv
// Round-robin or fixed-priority arbiter.
// Ports: req/ptr in; one-hot gnt, gnt_idx, any out.
module alias_rr_arbiter
  import alias_pkg::*;
#(
  parameter int         N    = 3,
  parameter alias_arb_e MODE = ALIAS_RR,
  localparam int        IW   = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned   idx;
  logic [IW-1:0] sel;
  logic          found;

  // Scan N slots starting at ptr (RR) or 0 (fixed);
  // the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == ALIAS_RR)
          ? (int'(ptr) + k) % N
          : k;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alias_hub.sv
// N-channel shared-value register with arbitrated writes.
// Ports: clk, rst_n, wr_*, lock in; rd_data, upd*, collisions out.
module alias_hub
  import alias_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               CHANNELS  = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'hdeadbeef),
  parameter alias_arb_e       ARB_MODE  = ALIAS_RR,
  parameter int               CNT_W     = 8,
  localparam int              IW        = idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       wr_valid,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  output logic [CHANNELS-1:0]       wr_grant,
  input  logic                      lock,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic                      upd,
  output logic [IW-1:0]             upd_src,
  output logic [CNT_W-1:0]          collisions
);

  logic [WIDTH-1:0]    shared_q, shared_d;
  logic [IW-1:0]       src_q, src_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                upd_q, upd_d;
  logic [CNT_W-1:0]    coll_q, coll_d;
  logic [CHANNELS-1:0] elig;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;

  // lock gates requests combinationally: same-cycle effect.
  assign elig = lock ? '0 : wr_valid;

  alias_rr_arbiter #(
    .N    (CHANNELS),
    .MODE (ARB_MODE)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt     (wr_grant),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    shared_d = shared_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    upd_d    = 1'b0;
    coll_d   = coll_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_grant[c]) begin
        shared_d = wr_data[c*WIDTH +: WIDTH];
      end
    end
    if (gnt_any) begin
      src_d = gnt_idx;
      upd_d = 1'b1;
      ptr_d = (gnt_idx == IW'(CHANNELS - 1))
            ? '0
            : gnt_idx + 1'b1;
    end
    // Saturating: holds at all-ones.
    if ($countones(elig) > 1 && coll_q != '1) begin
      coll_d = coll_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shared_q <= RESET_VAL;
      src_q    <= '0;
      ptr_q    <= '0;
      upd_q    <= 1'b0;
      coll_q   <= '0;
    end else begin
      shared_q <= shared_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      upd_q    <= upd_d;
      coll_q   <= coll_d;
    end
  end

  assign rd_data    = {CHANNELS{shared_q}};
  assign upd        = upd_q;
  assign upd_src    = src_q;
  assign collisions = coll_q;

endmodule

// File: tb/tb_alias_hub.sv
// Scoreboard bench for alias_hub.
// RR instance (defaults) plus FIXED instance with CNT_W=2.
module tb_alias_hub;
  import alias_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [2:0]  v_r = '0, v_f = '0;
  logic [95:0] d_r = '0, d_f = '0;
  logic        lk_r = 1'b0, lk_f = 1'b0;
  logic [2:0]  g_r, g_f;
  logic [95:0] rd_r, rd_f;
  logic        u_r, u_f;
  logic [1:0]  s_r, s_f;
  logic [7:0]  c_r;
  logic [1:0]  c_f;

  exp_t q_r[$];
  exp_t q_f[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alias_hub u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (v_r),
    .wr_data    (d_r),
    .wr_grant   (g_r),
    .lock       (lk_r),
    .rd_data    (rd_r),
    .upd        (u_r),
    .upd_src    (s_r),
    .collisions (c_r)
  );

  alias_hub #(
    .ARB_MODE (ALIAS_FIXED),
    .CNT_W    (2)
  ) u_fx (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (v_f),
    .wr_data    (d_f),
    .wr_grant   (g_f),
    .lock       (lk_f),
    .rd_data    (rd_f),
    .upd        (u_f),
    .upd_src    (s_f),
    .collisions (c_f)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm,
                        input logic [95:0] rd,
                        input logic [31:0] exp);
    logic [95:0] t;
    t = rd;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s[%0d]", nm, i), t[i*32 +: 32], exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every upd pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && u_r) begin
      if (q_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexp_upd: got upd=1 want none queued");
      end else begin
        exp_t e;
        e = q_r.pop_front();
        chk_rd("rr_rd", rd_r, e.d);
        chk("rr_src", 32'(s_r), 32'(e.s));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && u_f) begin
      if (q_f.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fx_unexp_upd: got upd=1 want none queued");
      end else begin
        exp_t e;
        e = q_f.pop_front();
        chk_rd("fx_rd", rd_f, e.d);
        chk("fx_src", 32'(s_f), 32'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // RR instance stimulus
  initial begin
    logic [31:0] pat[3];
    pat[0] = 32'haaaa0000;
    pat[1] = 32'hbbbb1111;
    pat[2] = 32'hcccc2222;
    repeat (3) go();
    rst_n = 1'b1;
    #1;
    chk_rd("rst_rd", rd_r, 32'hdeadbeef);
    chk("rst_upd", 32'(u_r), 0);
    chk("rst_coll", 32'(c_r), 0);
    chk("rst_src", 32'(s_r), 0);
    go();
    chk("idle_grant", 32'(g_r), 0);

    // all three request for three cycles
    for (int i = 0; i < 3; i++) d_r[i*32 +: 32] = pat[i];
    v_r = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 32'(g_r),
          32'(3'b001 << i));
      q_r.push_back('{d: pat[i], s: 2'(i)});
      go();
    end
    v_r = '0;
    chk("rr_coll3", 32'(c_r), 3);
    chk_rd("rr_final", rd_r, pat[2]);

    // single write on ch1
    go();
    d_r[32 +: 32] = 32'h12345678;
    v_r = 3'b010;
    #1;
    chk("w1_grant", 32'(g_r), 32'b010);
    q_r.push_back('{d: 32'h12345678, s: 2'd1});
    go();
    v_r = '0;
    chk("w1_upd", 32'(u_r), 1);
    chk("w1_coll", 32'(c_r), 3);

    // lock blocks a pending ch1 write of zero
    go();
    lk_r = 1'b1;
    d_r[32 +: 32] = 32'h0;
    v_r = 3'b010;
    #1;
    chk("lock_grant", 32'(g_r), 0);
    go();
    chk("lock_upd", 32'(u_r), 0);
    chk_rd("lock_rd", rd_r, 32'h12345678);
    chk("lock_coll", 32'(c_r), 3);
    lk_r = 1'b0;
    #1;
    chk("unlock_grant", 32'(g_r), 32'b010);
    q_r.push_back('{d: 32'h0, s: 2'd1});
    go();
    v_r = '0;

    // reset pulse between grant and edge discards the write
    go();
    d_r[31:0] = 32'h55aa55aa;
    v_r = 3'b001;
    #1;
    chk("pre_rst_grant", 32'(g_r), 32'b001);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rd("async_rst_rd", rd_r, 32'hdeadbeef);
    v_r = '0;
    #1;
    rst_n = 1'b1;
    go();
    chk_rd("post_rst_rd", rd_r, 32'hdeadbeef);
    chk("post_rst_upd", 32'(u_r), 0);
    chk("post_rst_coll", 32'(c_r), 0);
  end

  // FIXED instance stimulus, then summary
  initial begin
    int ec;
    wait (rst_n === 1'b1);
    repeat (3) go();
    d_f[31:0]  = 32'h11110000;
    d_f[64 +: 32] = 32'h22220002;
    v_f = 3'b101;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("fx_grant%0d", i), 32'(g_f), 32'b001);
      q_f.push_back('{d: 32'h11110000, s: 2'd0});
      go();
      ec = (i + 1 > 3) ? 3 : i + 1;
      chk($sformatf("fx_coll%0d", i), 32'(c_f), ec);
    end
    v_f = 3'b100;
    #1;
    chk("fx_grant_ch2", 32'(g_f), 32'b100);
    q_f.push_back('{d: 32'h22220002, s: 2'd2});
    go();
    v_f = '0;
    chk("fx_coll_hold", 32'(c_f), 3);

    // let the RR sequence finish, then drain
    repeat (30) go();
    chk("rr_queue_empty", 32'(q_r.size()), 0);
    chk("fx_queue_empty", 32'(q_f.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
